fc_writeback: RTL and testbench

// - Output stage of the FC engine. Consumes signed accumulator results from multiplier_accumulator, one neuron per acc_valid.
// - Rounds, shifts, applies optional ReLU and saturates each result to int8.
// - Scatters the int8 results across SRAM e0~e4, 4 bytes per address, under byte masks.
// - Tracks an argmax over the layer and reports the winning class index when the layer finishes.

---
 rtl/lenet_pkg.sv | 26 ++
 rtl/fc_quantizer.sv | 30 +++
 rtl/fc_writeback.sv | 213 +++++++++++++++++++++
 tb/tb_fc_writeback.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// lenet_pkg: shared constants, FSM encoding and small helpers for the LeNet FC datapath.
package lenet_pkg;

    localparam int ACC_WIDTH       = 32;
    localparam int DATA_WIDTH      = 8;
    localparam int NEURON_CNT_W    = 10;
    localparam int SRAM_ADDR_WIDTH = 10;
    localparam int SHIFT_W         = 5;

    localparam int NUM_BANK_E      = 5;
    localparam int BYTES_PER_ADDR  = 4;
    localparam int INT8_MAX        = 127;
    localparam int INT8_MIN        = -128;

    // Writeback control: IDLE waits for a layer, RUN owns the write ports.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } wb_state_e;

    // Active-low lane mask: only the selected byte lane is written.
    function automatic logic [BYTES_PER_ADDR-1:0] lane_mask(input logic [1:0] lane);
        lane_mask = ~(4'b0001 << lane);
    endfunction

endpackage

// File: rtl/fc_quantizer.sv
// fc_quantizer: arithmetic shift of a pre-rounded sum, optional ReLU, saturation to int8.
module fc_quantizer
    import lenet_pkg::*;
(
    input  logic signed [ACC_WIDTH:0]    sum,
    input  logic        [SHIFT_W-1:0]    shift,
    input  logic                         relu_en,
    output logic signed [DATA_WIDTH-1:0] q
);

    localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH+1)'(INT8_MAX);
    localparam logic signed [ACC_WIDTH:0] SAT_LO = (ACC_WIDTH+1)'(INT8_MIN);

    logic signed [ACC_WIDTH:0] shifted;

    // The rounding half-LSB was already added upstream; only shift, clamp and saturate here.
    always_comb begin
        shifted = sum >>> shift;
        if (relu_en && shifted[ACC_WIDTH]) begin
            q = '0;
        end else if (shifted > SAT_HI) begin
            q = 8'sh7F;
        end else if (shifted < SAT_LO) begin
            q = 8'sh80;
        end else begin
            q = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fc_writeback.sv
// fc_writeback: FC output stage. Two-cycle pipeline from acc_valid to an SRAM e write,
// bank/lane/address counters for the scatter, and a running argmax reported at layer_done.
// Handshake: no backpressure; acc_valid is a one-cycle qualifier for acc_data and every
// accepted value produces exactly one write strobe two cycles later.
module fc_writeback
    import lenet_pkg::*;
(
    input  logic                       clk,
    input  logic                       srstn,
    input  logic                       layer_start,
    input  logic [NEURON_CNT_W-1:0]    num_neuron,
    input  logic [SHIFT_W-1:0]         shift,
    input  logic                       relu_en,
    input  logic [SRAM_ADDR_WIDTH-1:0] base_addr,
    input  logic                       acc_valid,
    input  logic [ACC_WIDTH-1:0]       acc_data,
    output logic                       sram_write_enable_e0,
    output logic                       sram_write_enable_e1,
    output logic                       sram_write_enable_e2,
    output logic                       sram_write_enable_e3,
    output logic                       sram_write_enable_e4,
    output logic [BYTES_PER_ADDR-1:0]  sram_bytemask_e,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_waddr_e,
    output logic [DATA_WIDTH-1:0]      sram_wdata_e,
    output logic                       layer_done,
    output logic [NEURON_CNT_W-1:0]    class_id,
    output logic                       overflow_err
);

    wb_state_e state, next_state;

    logic [NEURON_CNT_W-1:0]    cfg_num;
    logic [SHIFT_W-1:0]         cfg_shift;
    logic                       cfg_relu;
    logic [SRAM_ADDR_WIDTH-1:0] cfg_base;

    logic [NEURON_CNT_W-1:0]    acc_cnt;
    logic [NEURON_CNT_W-1:0]    wr_cnt;
    logic [2:0]                 bank_cnt;
    logic [1:0]                 lane_cnt;
    logic [SRAM_ADDR_WIDTH-1:0] off_cnt;

    logic                        s1_valid;
    logic signed [ACC_WIDTH:0]   s1_sum;
    logic signed [ACC_WIDTH:0]   s1_next;
    logic signed [ACC_WIDTH:0]   round_add;
    logic signed [DATA_WIDTH-1:0] q;
    logic signed [DATA_WIDTH-1:0] best_val;
    logic [NEURON_CNT_W-1:0]     best_idx;

    logic busy, accept, drop, do_write, last_write;
    logic [NUM_BANK_E-1:0] we_n;
    logic [NUM_BANK_E-1:0] bank_sel_n;

    // FSM state register.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) state <= ST_IDLE;
        else        state <= next_state;
    end

    // FSM next state: a start always (re)enters RUN; the final write returns to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (layer_start) next_state = ST_RUN;
            ST_RUN: begin
                if (layer_start)     next_state = ST_RUN;
                else if (last_write) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: accept/drop decision and write qualifiers; a start masks everything in flight.
    always_comb begin
        busy       = (state == ST_RUN);
        accept     = acc_valid && !layer_start && busy && (acc_cnt != cfg_num);
        drop       = acc_valid && !layer_start && !accept;
        do_write   = s1_valid && !layer_start;
        last_write = do_write && (wr_cnt == cfg_num - NEURON_CNT_W'(1));
    end

    // Layer configuration latched on the start pulse.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            cfg_num   <= '0;
            cfg_shift <= '0;
            cfg_relu  <= 1'b0;
            cfg_base  <= '0;
        end else if (layer_start) begin
            cfg_num   <= num_neuron;
            cfg_shift <= shift;
            cfg_relu  <= relu_en;
            cfg_base  <= base_addr;
        end
    end

    // S1 rounding add: sign-extend by one bit so the half-LSB add cannot overflow.
    always_comb begin
        round_add = '0;
        if (cfg_shift != '0) round_add = (ACC_WIDTH+1)'(1) << (cfg_shift - SHIFT_W'(1));
        s1_next = $signed({acc_data[ACC_WIDTH-1], acc_data}) + round_add;
    end

    // S1 pipeline register.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) s1_sum <= s1_next;
        end
    end

    fc_quantizer u_quant (
        .sum     (s1_sum),
        .shift   (cfg_shift),
        .relu_en (cfg_relu),
        .q       (q)
    );

    // Accepted-result counter and sticky overflow flag for surplus or out-of-layer results.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            acc_cnt      <= '0;
            overflow_err <= 1'b0;
        end else if (layer_start) begin
            acc_cnt      <= '0;
            overflow_err <= 1'b0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + NEURON_CNT_W'(1);
        end else if (drop) begin
            overflow_err <= 1'b1;
        end
    end

    // Scatter counters (bank, then lane, then address) and running argmax, advanced per write.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            wr_cnt   <= '0;
            bank_cnt <= '0;
            lane_cnt <= '0;
            off_cnt  <= '0;
            best_val <= DATA_WIDTH'(INT8_MIN);
            best_idx <= '0;
        end else if (layer_start) begin
            wr_cnt   <= '0;
            bank_cnt <= '0;
            lane_cnt <= '0;
            off_cnt  <= '0;
            best_val <= DATA_WIDTH'(INT8_MIN);
            best_idx <= '0;
        end else if (do_write) begin
            wr_cnt <= wr_cnt + NEURON_CNT_W'(1);
            // Strictly greater, so a tie keeps the earlier index.
            if (q > best_val) begin
                best_val <= q;
                best_idx <= wr_cnt;
            end
            if (bank_cnt == 3'(NUM_BANK_E - 1)) begin
                bank_cnt <= '0;
                if (lane_cnt == 2'(BYTES_PER_ADDR - 1)) begin
                    lane_cnt <= '0;
                    off_cnt  <= off_cnt + SRAM_ADDR_WIDTH'(1);
                end else begin
                    lane_cnt <= lane_cnt + 2'd1;
                end
            end else begin
                bank_cnt <= bank_cnt + 3'd1;
            end
        end
    end

    // One-hot active-low bank select from the bank counter.
    always_comb begin
        bank_sel_n = ~(NUM_BANK_E'(1) << bank_cnt);
    end

    // Registered write ports: idle values unless a write issues this cycle.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            we_n            <= '1;
            sram_bytemask_e <= '1;
            sram_waddr_e    <= '0;
            sram_wdata_e    <= '0;
            layer_done      <= 1'b0;
            class_id        <= '0;
        end else begin
            we_n            <= '1;
            sram_bytemask_e <= '1;
            sram_waddr_e    <= '0;
            sram_wdata_e    <= '0;
            layer_done      <= 1'b0;
            if (do_write) begin
                we_n            <= bank_sel_n;
                sram_bytemask_e <= lane_mask(lane_cnt);
                sram_waddr_e    <= cfg_base + off_cnt;
                sram_wdata_e    <= q;
                layer_done      <= last_write;
                // The final neuron still competes for the argmax in its own write cycle.
                if (last_write) class_id <= (q > best_val) ? wr_cnt : best_idx;
            end
        end
    end

    assign sram_write_enable_e0 = we_n[0];
    assign sram_write_enable_e1 = we_n[1];
    assign sram_write_enable_e2 = we_n[2];
    assign sram_write_enable_e3 = we_n[3];
    assign sram_write_enable_e4 = we_n[4];

endmodule

// File: tb/tb_fc_writeback.sv
// tb_fc_writeback: randomized and directed stimulus with a queue-based scoreboard for fc_writeback.
module tb_fc_writeback;

    localparam int EW = 38;  // {we[4:0], mask[3:0], addr[9:0], data[7:0], done, class[9:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic srstn;
    always #5 clk = ~clk;

    logic        layer_start;
    logic [9:0]  num_neuron;
    logic [4:0]  shift;
    logic        relu_en;
    logic [9:0]  base_addr;
    logic        acc_valid;
    logic [31:0] acc_data;
    logic        we0, we1, we2, we3, we4;
    logic [3:0]  mask;
    logic [9:0]  waddr;
    logic [7:0]  wdata;
    logic        layer_done;
    logic [9:0]  class_id;
    logic        overflow_err;

    fc_writeback dut (
        .clk                  (clk),
        .srstn                (srstn),
        .layer_start          (layer_start),
        .num_neuron           (num_neuron),
        .shift                (shift),
        .relu_en              (relu_en),
        .base_addr            (base_addr),
        .acc_valid            (acc_valid),
        .acc_data             (acc_data),
        .sram_write_enable_e0 (we0),
        .sram_write_enable_e1 (we1),
        .sram_write_enable_e2 (we2),
        .sram_write_enable_e3 (we3),
        .sram_write_enable_e4 (we4),
        .sram_bytemask_e      (mask),
        .sram_waddr_e         (waddr),
        .sram_wdata_e         (wdata),
        .layer_done           (layer_done),
        .class_id             (class_id),
        .overflow_err         (overflow_err)
    );

    // ---------------- scoreboard state and reference model ----------------
    logic [EW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    int m_num, m_cnt, m_shift, m_base, m_class;
    bit m_relu, m_active, m_ovf;
    int m_vals[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Quantization as written in the datasheet arithmetic: round-half-up, floor shift, clamp.
    function automatic int model_q(input logic [31:0] acc, input int sh, input bit relu);
        longint v;
        v = longint'($signed(acc));
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (relu && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return int'(v);
    endfunction

    function automatic int argmax();
        int b = 0;
        for (int i = 1; i < m_vals.size(); i++)
            if (m_vals[i] > m_vals[b]) b = i;
        return b;
    endfunction

    function automatic logic [EW-1:0] make_exp(input int n, input int q, input bit done, input int cls);
        logic [4:0] we;
        logic [3:0] mk;
        logic [9:0] ad;
        logic [7:0] d;
        we = 5'h1F;
        we[3'(n % 5)] = 1'b0;
        mk = 4'hF;
        mk[2'((n / 5) % 4)] = 1'b0;
        ad = 10'((m_base + (n / 5) / 4) % 1024);
        d  = 8'(q);
        return {we, mk, ad, d, done, done ? 10'(cls) : 10'd0};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            acc_valid = 1'b0;
        end
    endtask

    task automatic start_layer(input int num, input int sh, input bit relu, input int base);
        @(posedge clk); #1;
        acc_valid   = 1'b0;
        layer_start = 1'b1;
        num_neuron  = 10'(num);
        shift       = 5'(sh);
        relu_en     = relu;
        base_addr   = 10'(base);
        @(posedge clk); #1;
        layer_start = 1'b0;
        // Anything still in flight at the start edge is aborted.
        exp_q.delete();
        m_vals.delete();
        m_num = num; m_cnt = 0; m_shift = sh; m_relu = relu; m_base = base;
        m_active = 1'b1; m_ovf = 1'b0;
    endtask

    // ovr = 999 means "use the reference model"; otherwise ovr is the quoted expected value.
    task automatic send(input logic [31:0] acc, input int ovr);
        int q;
        bit done;
        @(posedge clk); #1;
        acc_valid = 1'b1;
        acc_data  = acc;
        if (m_active && m_cnt < m_num) begin
            q = (ovr == 999) ? model_q(acc, m_shift, m_relu) : ovr;
            m_vals.push_back(q);
            done = (m_cnt == m_num - 1);
            if (done) m_class = argmax();
            exp_q.push_back(make_exp(m_cnt, q, done, m_class));
            m_cnt++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending_writes", exp_q.size(), 0);
    endtask

    task automatic check_ovf(input string name);
        idle(2);
        chk(name, overflow_err, m_ovf);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_strobes"}, {we4, we3, we2, we1, we0}, 5'h1F);
        chk({tag, "_mask"}, mask, 4'hF);
        chk({tag, "_waddr"}, waddr, 10'h0);
        chk({tag, "_wdata"}, wdata, 8'h0);
        chk({tag, "_layer_done"}, layer_done, 1'b0);
        chk({tag, "_class_id"}, class_id, 10'h0);
        chk({tag, "_overflow"}, overflow_err, 1'b0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [4:0]    we;
        logic [EW-1:0] act;
        logic [EW-1:0] exp;
        if (srstn) begin
            we = {we4, we3, we2, we1, we0};
            if (we != 5'h1F) begin
                act = {we, mask, waddr, wdata, layer_done, layer_done ? class_id : 10'd0};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write_unexpected actual=%0h required=no_write at %0t", act, $time);
                end else begin
                    exp = exp_q.pop_front();
                    chk("write_record", act, exp);
                end
            end else begin
                chk("idle_ports", {mask, waddr, wdata, layer_done}, {4'hF, 10'h0, 8'h0, 1'b0});
            end
        end
    end

    // ---------------- stimulus ----------------
    int vals_argmax[10] = '{3, -5, 9, 40, 2, 7, 0, 40, 1, -128};

    initial begin
        srstn = 1'b0; layer_start = 1'b0; num_neuron = '0; shift = '0; relu_en = 1'b0;
        base_addr = '0; acc_valid = 1'b0; acc_data = '0;
        m_active = 1'b0; m_ovf = 1'b0; m_cnt = 0; m_num = 0; m_base = 0; m_class = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_check("reset");
        srstn = 1'b1;
        idle(2);

        // Result while idle: dropped and flagged.
        send(32'd5, 999);
        check_ovf("ovf_idle");

        // Rounding with ReLU on.
        start_layer(1, 4, 1'b1, 10'h020);
        chk("ovf_cleared_by_start", overflow_err, 1'b0);
        send(32'd312, 20);
        drain();
        chk("class_single", class_id, 10'd0);

        // Negative value without and with ReLU.
        start_layer(1, 4, 1'b0, 10'h000);
        send(-32'sd312, -19);
        drain();
        start_layer(1, 4, 1'b1, 10'h000);
        send(-32'sd312, 0);
        drain();

        // Saturation.
        start_layer(3, 0, 1'b0, 10'h100);
        send(32'h7FFF_FFFF, 127);
        send(32'h8000_0000, -128);
        send(32'h0000_0000, 0);
        drain();
        chk("class_sat", class_id, 10'd0);

        // Addressing over 26 back-to-back neurons.
        start_layer(26, 0, 1'b0, 10'h010);
        for (int i = 0; i < 26; i++) send(32'($urandom_range(0, 400)) - 32'd200, 999);
        drain();

        // Argmax with ties, then an 11th result.
        start_layer(10, 0, 1'b0, 10'h040);
        for (int i = 0; i < 10; i++) send(32'(vals_argmax[i]), vals_argmax[i]);
        send(32'd77, 999);
        drain();
        chk("class_argmax", class_id, 10'd3);
        chk("ovf_surplus", overflow_err, 1'b1);
        idle(5);
        chk("class_held", class_id, 10'd3);
        start_layer(4, 2, 1'b0, 10'h050);
        chk("ovf_cleared", overflow_err, 1'b0);

        // Abort with a new start mid-layer; only the second layer's writes may appear.
        send(32'd100, 999);
        send(32'd200, 999);
        send(32'd300, 999);
        start_layer(4, 1, 1'b1, 10'h060);
        for (int i = 0; i < 4; i++) send(32'($urandom_range(0, 2000)) - 32'd1000, 999);
        drain();
        chk("class_after_abort", class_id, 10'(m_class));
        chk("ovf_after_abort", overflow_err, 1'b0);

        // Asynchronous reset while neuron 2's write is on the ports.
        start_layer(20, 0, 1'b0, 10'h070);
        for (int i = 0; i < 5; i++) send(32'd10 + 32'(i), 999);
        #3;
        srstn = 1'b0;
        acc_valid = 1'b0;
        #1;
        reset_check("midreset");
        exp_q.delete();
        m_active = 1'b0; m_ovf = 1'b0; m_cnt = 0;
        @(posedge clk); #1;
        srstn = 1'b1;
        idle(3);

        // Randomized layers, including an address wrap past 1023.
        for (int l = 0; l < 8; l++) begin
            int num, sh, base;
            bit relu;
            logic [31:0] a;
            num  = $urandom_range(1, 45);
            sh   = $urandom_range(0, 31);
            relu = 1'($urandom_range(0, 1));
            base = (l == 0) ? 1023 : $urandom_range(0, 1023);
            start_layer(num, sh, relu, base);
            for (int k = 0; k < num; k++) begin
                if ($urandom_range(0, 2) == 0) idle(1);
                case ($urandom_range(0, 2))
                    0:       a = $urandom();
                    1:       a = 32'($urandom_range(0, 20000)) - 32'd10000;
                    default: a = 32'($urandom_range(0, 3000)) - 32'd1000;
                endcase
                send(a, 999);
            end
            drain();
            chk("class_random", class_id, 10'(m_class));
            chk("ovf_random", overflow_err, 1'b0);
        end

        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the bench always ends.
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
